// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared word width, FSM encoding and default wait states for data_mem_responder
package data_mem_responder_pkg;

    localparam int WORD_LEN            = 32;
    localparam int DEFAULT_WAIT_CYCLES = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/data_mem_responder_array.sv
// rtl/data_mem_responder_array.sv - dmem_array: single-port DEPTH x WORD_LEN store, sync write/clear, comb read
module dmem_array
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    addr,
    input  logic [WORD_LEN-1:0] wdata,
    output logic [WORD_LEN-1:0] rdata
);

    logic [WORD_LEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-stated data memory for the MEM stage; DMEM_ALIGN_CHECK_EN adds addr_err
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int BASE_ADDR   = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_rd_en,
    input  logic                req_wr_en,
    input  logic [WORD_LEN-1:0] req_addr,
    input  logic [WORD_LEN-1:0] req_wdata,
    output logic [WORD_LEN-1:0] rsp_rdata,
    output logic                rsp_ready,
    output logic                stall
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    output logic                addr_err
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    dmem_state_t         state, state_next;
    logic [3:0]          cnt;
    logic [WORD_LEN-1:0] addr_q, wdata_q, offset, arr_rdata;
    logic                wr_q, accept, fire, bad;
    logic [IDX_W-1:0]    idx;

    assign offset = addr_q - WORD_LEN'(BASE_ADDR);
    assign idx    = offset[IDX_W+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign bad = (addr_q[1:0] != 2'b00)
              || (addr_q < WORD_LEN'(BASE_ADDR))
              || ((offset >> 2) >= WORD_LEN'(DEPTH));
    assign addr_err = !rst && (state == DONE) && bad;
`else
    // Without the check, byte offset and high index bits are simply dropped (wrap mode).
    logic unused_offset;
    assign unused_offset = ^{offset[1:0], offset[WORD_LEN-1:IDX_W+2]};
    assign bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        fire       = 1'b0;
        stall      = 1'b0;
        rsp_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (req_rd_en || req_wr_en) begin
                    accept     = 1'b1;
                    stall      = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (cnt == 4'd0) begin
                    fire       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                rsp_ready  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (rst) begin
            accept    = 1'b0;
            fire      = 1'b0;
            stall     = 1'b0;
            rsp_ready = 1'b0;
        end
    end

    // A simultaneous read+write latches as a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wr_q    <= req_wr_en;
                cnt     <= 4'(WAIT_CYCLES - 1);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (fire && !wr_q) begin
                rsp_rdata <= bad ? '0 : arr_rdata;
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .clr   (rst),
        .wr_en (fire && wr_q && !bad),
        .addr  (idx),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder (WAIT_CYCLES 3 and 1 instances)
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        rd_en   [2];
    logic        wr_en   [2];
    logic [31:0] addr_r  [2];
    logic [31:0] wdata_r [2];
    logic [31:0] rdata   [2];
    logic        ready   [2];
    logic        stall   [2];
`ifdef DMEM_ALIGN_CHECK_EN
    logic        err     [2];
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [10];

    data_mem_responder dut0 (
        .clk       (clk),
        .rst       (rst),
        .req_rd_en (rd_en[0]),
        .req_wr_en (wr_en[0]),
        .req_addr  (addr_r[0]),
        .req_wdata (wdata_r[0]),
        .rsp_rdata (rdata[0]),
        .rsp_ready (ready[0]),
        .stall     (stall[0])
`ifdef DMEM_ALIGN_CHECK_EN
        ,
        .addr_err  (err[0])
`endif
    );

    data_mem_responder #(.WAIT_CYCLES(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .req_rd_en (rd_en[1]),
        .req_wr_en (wr_en[1]),
        .req_addr  (addr_r[1]),
        .req_wdata (wdata_r[1]),
        .rsp_rdata (rdata[1]),
        .rsp_ready (ready[1]),
        .stall     (stall[1])
`ifdef DMEM_ALIGN_CHECK_EN
        ,
        .addr_err  (err[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One complete access; checks latency, stall length and addr_err, returns rsp_rdata at DONE.
    task automatic access(input int d, input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input int w, input logic exp_err,
                          output logic [31:0] rdout);
        int   stalls;
        int   lat;
        logic err_seen;
        @(posedge clk); #1;
        rd_en[d] = rd; wr_en[d] = wr; addr_r[d] = addr; wdata_r[d] = wd;
        #1;
        stalls   = stall[d] ? 1 : 0;
        lat      = -1;
        err_seen = 1'b0;
        rdout    = 'x;
        for (int cyc = 1; cyc <= 40 && lat < 0; cyc++) begin
            @(posedge clk); #1;
            rd_en[d] = 1'b0; wr_en[d] = 1'b0;
            if (stall[d]) stalls++;
            if (ready[d]) begin
                lat   = cyc;
                rdout = rdata[d];
`ifdef DMEM_ALIGN_CHECK_EN
                err_seen = err[d];
`endif
            end
        end
        check($sformatf("dut%0d_latency_0x%0h", d, addr), lat, w + 1);
        check($sformatf("dut%0d_stall_cycles_0x%0h", d, addr), stalls, w + 1);
`ifdef DMEM_ALIGN_CHECK_EN
        check($sformatf("dut%0d_addr_err_0x%0h", d, addr), {31'b0, err_seen}, {31'b0, exp_err});
`else
        if (exp_err) check("addr_err_unexpected_expectation", 32'd1, 32'd0);
`endif
    endtask

    initial begin
        logic [31:0] got;
        int          first_t, second_t;
        logic [31:0] first_d, second_d;
        logic        seen_ready;

        tbl[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h0000_0000};
        tbl[1] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF};
        tbl[2] = '{1'b1, 1'b1, 32'd1028, 32'h12345678, 32'hDEADBEEF};
        tbl[3] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'h12345678};
        tbl[4] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'h0000_0000};
        tbl[5] = '{1'b0, 1'b1, 32'd1032, 32'hCAFEF00D, 32'h0000_0000};
        tbl[6] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'hCAFEF00D};
        tbl[7] = '{1'b0, 1'b1, 32'd1276, 32'hA5A5A5A5, 32'hCAFEF00D};
        tbl[8] = '{1'b1, 1'b0, 32'd1276, 32'h0,        32'hA5A5A5A5};
        tbl[9] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF};

        for (int d = 0; d < 2; d++) begin
            rd_en[d] = 1'b0; wr_en[d] = 1'b0; addr_r[d] = '0; wdata_r[d] = '0;
        end

        // Reset overrides a request held high.
        rst = 1'b1;
        rd_en[0] = 1'b1; addr_r[0] = 32'd1024;
        repeat (3) @(posedge clk);
        #1;
        check("reset_stall_with_enable", {31'b0, stall[0]}, 32'd0);
        check("reset_ready", {31'b0, ready[0]}, 32'd0);
        rd_en[0] = 1'b0;
        rst = 1'b0;
        #1;
        check("reset_rdata", rdata[0], 32'h0);
        check("reset_idle_stall", {31'b0, stall[0]}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            access(0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, 3, 1'b0, got);
            check($sformatf("vec%0d_rdata", i), got, tbl[i].exp);
        end

        // Back-to-back reads with enables held through DONE.
        @(posedge clk); #1;
        rd_en[0] = 1'b1; addr_r[0] = 32'd1024;
        first_t = -1; second_t = -1; first_d = '0; second_d = '0;
        for (int cyc = 1; cyc <= 40 && second_t < 0; cyc++) begin
            @(posedge clk); #1;
            if (ready[0]) begin
                if (first_t < 0) begin
                    first_t = cyc; first_d = rdata[0]; addr_r[0] = 32'd1032;
                end else begin
                    second_t = cyc; second_d = rdata[0]; rd_en[0] = 1'b0;
                end
            end
        end
        check("b2b_first_latency", first_t, 32'd4);
        check("b2b_second_latency", second_t, 32'd9);
        check("b2b_first_rdata", first_d, 32'hDEADBEEF);
        check("b2b_second_rdata", second_d, 32'hCAFEF00D);
        @(posedge clk); #1;
        check("b2b_no_third_access", {31'b0, stall[0]}, 32'd0);

        // WAIT_CYCLES=1 instance.
        access(1, 1'b0, 1'b1, 32'd1024, 32'h0BADCAFE, 1, 1'b0, got);
        check("w1_write_leaves_rdata", got, 32'h0);
        access(1, 1'b1, 1'b0, 32'd1024, 32'h0, 1, 1'b0, got);
        check("w1_read_rdata", got, 32'h0BADCAFE);

        // Reset during the second WAIT cycle aborts the write.
        @(posedge clk); #1;
        wr_en[0] = 1'b1; addr_r[0] = 32'd1040; wdata_r[0] = 32'h55;
        @(posedge clk); #1;
        wr_en[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_abort_stall", {31'b0, stall[0]}, 32'd0);
        check("rst_abort_rdata", rdata[0], 32'h0);
        seen_ready = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(posedge clk); #1;
            if (ready[0]) seen_ready = 1'b1;
        end
        check("rst_abort_no_ready", {31'b0, seen_ready}, 32'd0);
        access(0, 1'b1, 1'b0, 32'd1040, 32'h0, 3, 1'b0, got);
        check("rst_abort_read_1040", got, 32'h0);
        access(0, 1'b1, 1'b0, 32'd1276, 32'h0, 3, 1'b0, got);
        check("rst_cleared_1276", got, 32'h0);

`ifdef DMEM_ALIGN_CHECK_EN
        access(0, 1'b0, 1'b1, 32'd1024, 32'h00000011, 3, 1'b0, got);
        access(0, 1'b0, 1'b1, 32'd1026, 32'hAAAA5555, 3, 1'b1, got);
        access(0, 1'b1, 1'b0, 32'd1024, 32'h0, 3, 1'b0, got);
        check("misaligned_no_write", got, 32'h00000011);
        access(0, 1'b1, 1'b0, 32'd1280, 32'h0, 3, 1'b1, got);
        check("out_of_range_read_zero", got, 32'h0);
        access(0, 1'b1, 1'b0, 32'd1020, 32'h0, 3, 1'b1, got);
        check("below_base_read_zero", got, 32'h0);
`else
        access(0, 1'b0, 1'b1, 32'd1026, 32'hAAAA5555, 3, 1'b0, got);
        access(0, 1'b1, 1'b0, 32'd1024, 32'h0, 3, 1'b0, got);
        check("misaligned_lands_word0", got, 32'hAAAA5555);
        access(0, 1'b0, 1'b1, 32'd1280, 32'h00000077, 3, 1'b0, got);
        access(0, 1'b1, 1'b0, 32'd1024, 32'h0, 3, 1'b0, got);
        check("wrap_lands_word0", got, 32'h00000077);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
